// File: rtl/water_tank_condition_gen_if.sv
// ---------------------------------------------------------------------------
// water_tank_condition_gen_if
// Groups the sensor inputs, the fault-clear request and the condition outputs
// of water_tank_condition_gen.
//   master : drives the raw switches and fault_clear, observes the outputs
//   slave  : the condition generator itself
// Signals:
//   level_low_raw      1 = water at or above the low mark (async)
//   level_high_raw     1 = water at or above the full mark (async)
//   soil_dry_raw       1 = soil dry (async)
//   fault_clear        single-cycle request to clear a latched fault
//   watering_condition request to water
//   filling_condition  request to fill the tank
//   sensor_fault       1 while a sensor fault is latched
//   tank_ready         tank filled and not yet drained below the low mark
// ---------------------------------------------------------------------------
interface water_tank_condition_gen_if;
  logic level_low_raw;
  logic level_high_raw;
  logic soil_dry_raw;
  logic fault_clear;
  logic watering_condition;
  logic filling_condition;
  logic sensor_fault;
  logic tank_ready;

  modport master (
    output level_low_raw, level_high_raw, soil_dry_raw, fault_clear,
    input  watering_condition, filling_condition, sensor_fault, tank_ready
  );

  modport slave (
    input  level_low_raw, level_high_raw, soil_dry_raw, fault_clear,
    output watering_condition, filling_condition, sensor_fault, tank_ready
  );
endinterface

// File: rtl/water_tank_condition_gen.sv
// ---------------------------------------------------------------------------
// water_tank_condition_gen
// Front end of the water tank controller: synchronizes and debounces the raw
// level/soil switches, keeps a fill/drain hysteresis flag, detects an
// impossible level combination (full mark wet while low mark dry) and
// produces the registered watering/filling conditions.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    water_tank_condition_gen_if.slave (sensors in, conditions out)
// Both conditions stay 0 during warm-up after reset and while a fault is
// latched. WARMUP_CYCLES must be at least max(LEVEL_DEBOUNCE, SOIL_DEBOUNCE)+2
// so the debounced levels have settled before the first RUN cycle.
// ---------------------------------------------------------------------------

// Per-input lane: two-flop synchronizer followed by a consecutive-mismatch
// debouncer. The debounced value flips only after N consecutive cycles in
// which the synchronized input disagrees with it.
module wtcg_debounce #(
  parameter int N         = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db
);
  logic [1:0]           sync;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == CNT_WIDTH'(N - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module water_tank_condition_gen #(
  parameter int LEVEL_DEBOUNCE = 16,
  parameter int SOIL_DEBOUNCE  = 64,
  parameter int FAULT_CYCLES   = 8,
  parameter int WARMUP_CYCLES  = 80,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  water_tank_condition_gen_if.slave  bus
);
  localparam int NUM_IN   = 3;
  localparam int IDX_LOW  = 0;
  localparam int IDX_HIGH = 1;
  localparam int IDX_SOIL = 2;

  typedef enum logic [1:0] {WARMUP, RUN, FAULT} state_t;

  // ---- input lanes --------------------------------------------------------
  logic [NUM_IN-1:0] raw_vec;
  logic [NUM_IN-1:0] db_vec;

  assign raw_vec[IDX_LOW]  = bus.level_low_raw;
  assign raw_vec[IDX_HIGH] = bus.level_high_raw;
  assign raw_vec[IDX_SOIL] = bus.soil_dry_raw;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    wtcg_debounce #(
      .N         ((i == IDX_SOIL) ? SOIL_DEBOUNCE : LEVEL_DEBOUNCE),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (raw_vec[i]),
      .db    (db_vec[i])
    );
  end

  logic low_db, high_db, soil_db;
  assign low_db  = db_vec[IDX_LOW];
  assign high_db = db_vec[IDX_HIGH];
  assign soil_db = db_vec[IDX_SOIL];

  // Full mark wet with low mark dry cannot happen physically.
  logic inconsistent;
  assign inconsistent = high_db & ~low_db;

  // ---- state machine ------------------------------------------------------
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] warm_q, warm_d;
  logic [CNT_WIDTH-1:0] cons_q, cons_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WARMUP;
      warm_q  <= '0;
      cons_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cons_q  <= cons_d;
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cons_d  = '0;
    case (state_q)
      WARMUP: begin
        if (warm_q == CNT_WIDTH'(WARMUP_CYCLES - 1)) begin
          state_d = RUN;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      RUN: begin
        if (inconsistent) begin
          if (cons_q == CNT_WIDTH'(FAULT_CYCLES - 1)) state_d = FAULT;
          else                                         cons_d  = cons_q + 1'b1;
        end
      end
      FAULT: begin
        // Clearing is only honoured once the levels look sane again.
        if (bus.fault_clear && !inconsistent) state_d = RUN;
      end
      default: state_d = WARMUP;
    endcase
  end

  // ---- hysteresis and registered outputs ----------------------------------
  logic tank_ready_q;
  logic tr_next;

  // Draining below low wins over everything; full (both marks wet) sets.
  always_comb begin
    tr_next = tank_ready_q;
    if (!low_db)                tr_next = 1'b0;
    else if (high_db && low_db) tr_next = 1'b1;
  end

  // Conditions are produced only on edges that both start and end in RUN, so
  // the edge entering FAULT already shows zeros alongside sensor_fault, and the
  // edge leaving FAULT comes out with tank_ready still cleared.
  logic run_out;
  assign run_out = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.watering_condition <= 1'b0;
      bus.filling_condition  <= 1'b0;
      bus.sensor_fault       <= 1'b0;
      tank_ready_q           <= 1'b0;
    end else begin
      bus.sensor_fault <= (state_d == FAULT);
      if (run_out) begin
        tank_ready_q           <= tr_next;
        bus.filling_condition  <= ~low_db;
        // Follows the next hysteresis value so a drain clears both together.
        bus.watering_condition <= tr_next & soil_db;
      end else begin
        tank_ready_q           <= 1'b0;
        bus.filling_condition  <= 1'b0;
        bus.watering_condition <= 1'b0;
      end
    end
  end

  assign bus.tank_ready = tank_ready_q;
endmodule

// File: tb/tb_water_tank_condition_gen.sv
module tb_water_tank_condition_gen;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  water_tank_condition_gen_if bus ();

  water_tank_condition_gen #(
    .LEVEL_DEBOUNCE (4),
    .SOIL_DEBOUNCE  (8),
    .FAULT_CYCLES   (3),
    .WARMUP_CYCLES  (12),
    .CNT_WIDTH      (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected {watering, filling, sensor_fault, tank_ready} at a given edge count.
  typedef struct {
    int         at;
    string      tag;
    logic [3:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t cur;

  logic [3:0] obs;
  assign obs = {bus.watering_condition, bus.filling_condition,
                bus.sensor_fault, bus.tank_ready};

  task automatic exp_at(input int off, input string tag, input logic [3:0] v);
    sb_t e;
    int  i;
    e.at  = cyc + off;
    e.tag = tag;
    e.exp = v;
    i = sb.size();
    while (i > 0 && sb[i-1].at > e.at) i--;
    sb.insert(i, e);
  endtask

  task automatic exp_span(input int from, input int to, input string tag,
                          input logic [3:0] v);
    for (int k = from; k <= to; k++) exp_at(k, tag, v);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      total++;
      assert (obs === cur.exp) else begin
        bad++;
        $error("FAIL %s cyc=%0d w/f/sf/tr got=%b want=%b", cur.tag, cyc, obs, cur.exp);
      end
    end
  end

  initial begin
    bus.level_low_raw  = 1'b0;
    bus.level_high_raw = 1'b0;
    bus.soil_dry_raw   = 1'b0;
    bus.fault_clear    = 1'b0;

    // reset state
    tick(3);
    exp_at(0, "reset", 4'b0000);
    tick(1);

    // warm-up: 12 cycles of zeros, then filling (low dry)
    reset = 1'b0;
    exp_span(1, 12, "warmup", 4'b0000);
    exp_at(13, "run_fill", 4'b0100);
    tick(13);

    // debounce: low wet -> filling falls 7 edges after the drive point
    bus.level_low_raw = 1'b1;
    exp_at(6, "db_before", 4'b0100);
    exp_at(7, "db_after", 4'b0000);
    tick(8);

    // 3-cycle glitch on low is absorbed
    exp_span(1, 12, "glitch", 4'b0000);
    bus.level_low_raw = 1'b0;
    tick(3);
    bus.level_low_raw = 1'b1;
    tick(9);

    // high wet -> tank_ready sets
    bus.level_high_raw = 1'b1;
    exp_at(6, "tr_before", 4'b0000);
    exp_at(7, "tr_set", 4'b0001);
    tick(8);

    // high dries -> tank_ready holds
    bus.level_high_raw = 1'b0;
    exp_span(1, 10, "tr_hold", 4'b0001);
    tick(10);

    // soil dry -> watering after SOIL_DEBOUNCE
    bus.soil_dry_raw = 1'b1;
    exp_at(10, "water_before", 4'b0001);
    exp_at(11, "water_on", 4'b1001);
    tick(12);

    // low dries -> ready/watering clear, filling sets, same edge
    bus.level_low_raw = 1'b0;
    exp_at(6, "drain_before", 4'b1001);
    exp_at(7, "drain", 4'b0100);
    tick(8);

    // high wet with low dry -> fault after 3 debounced cycles
    bus.level_high_raw = 1'b1;
    exp_at(8, "fault_before", 4'b0100);
    exp_at(9, "fault_on", 4'b0010);
    tick(10);

    // clear while still inconsistent is ignored
    exp_span(1, 4, "clr_ignored", 4'b0010);
    bus.fault_clear = 1'b1;
    tick(1);
    bus.fault_clear = 1'b0;
    tick(4);

    // restore low; fault stays latched until cleared
    bus.level_low_raw = 1'b1;
    exp_span(1, 8, "fault_hold", 4'b0010);
    tick(8);

    // clear -> RUN next edge with ready 0, then ready/watering resume
    bus.fault_clear = 1'b1;
    exp_at(1, "clr_edge", 4'b0000);
    exp_at(2, "clr_run", 4'b1001);
    tick(1);
    bus.fault_clear = 1'b0;
    tick(2);

    // mid-operation reset while watering
    reset = 1'b1;
    exp_span(1, 13, "mid_reset", 4'b0000);
    exp_at(14, "rerun", 4'b1001);
    tick(1);
    reset = 1'b0;
    tick(15);

    // drain any remaining expectations, bounded
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clock);
    @(posedge clock);
    #1;
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
